snn_window_ctrl: RTL

- Sequences one inference window of the spiking output layer.
- On a start handshake, it pulses a clear to the layer. It then enables the layer for WINDOW_LEN timesteps and counts spikes per output node.
- After the window, it finds the winning node with a sequential argmax scan. It presents the winner index and count on a valid/ready result port.
- Sits between the input-encoding scheduler and the host/readout logic, and replaces free-running spike counting with bounded, restartable windows.

---
 rtl/snn_window_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/snn_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : snn_window_ctrl
//  Purpose  : Sequences one inference window of the spiking output layer:
//             clear pulse, WINDOW_LEN enabled timesteps with per-node
//             saturating spike counting, sequential argmax scan, and a
//             valid/ready result hand-off.
//  Revision : 1.0 - initial release
// ============================================================================
module snn_window_ctrl #(
  parameter int NUM_NODES  = 10,
  parameter int WINDOW_LEN = 256,
  parameter int CNT_W      = 16,
  parameter int IDX_W      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 start_ready_o,
  input  logic                 abort_i,
  input  logic [NUM_NODES-1:0] nodes_i,
  output logic                 layer_clr_o,
  output logic                 layer_en_o,
  output logic                 busy_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [IDX_W-1:0]     winner_o,
  output logic [CNT_W-1:0]     winner_cnt_o,
  output logic                 no_spike_o
);

  // Timestep counter only needs to reach WINDOW_LEN-1 before RUN is left.
  localparam int TS_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;

  localparam logic [TS_W-1:0]  c_ts_last  = TS_W'(WINDOW_LEN - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_NODES - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_SCAN   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_cnt [NUM_NODES];

  logic [IDX_W-1:0] r_scan_idx;
  logic [IDX_W-1:0] r_best_idx;
  logic [CNT_W-1:0] r_best_cnt;

  logic [IDX_W-1:0] r_winner;
  logic [CNT_W-1:0] r_winner_cnt;
  logic             r_no_spike;

  logic             w_ts_last;
  logic             w_scan_last;
  logic [CNT_W-1:0] w_cur_cnt;
  logic             w_better;
  logic [IDX_W-1:0] w_best_idx_nxt;
  logic [CNT_W-1:0] w_best_cnt_nxt;

  assign w_ts_last   = (r_ts == c_ts_last);
  assign w_scan_last = (r_scan_idx == c_idx_last);

  // State register; reset forces IDLE immediately, so no clear pulse follows.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and Moore outputs; abort outranks the end-of-phase transitions.
  always_comb begin
    w_state_nxt    = r_state;
    start_ready_o  = 1'b0;
    layer_clr_o    = 1'b0;
    layer_en_o     = 1'b0;
    busy_o         = 1'b1;
    result_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o        = 1'b0;
        start_ready_o = 1'b1;
        if (start_i) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        layer_clr_o = 1'b1;
        w_state_nxt = abort_i ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        layer_en_o = 1'b1;
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_ts_last) begin
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_scan_last) begin
          w_state_nxt = S_RESULT;
        end
      end
      S_RESULT: begin
        result_valid_o = 1'b1;
        if (result_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Timestep counter: zeroed in CLEAR, advances once per RUN sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ts <= '0;
    end else if (r_state == S_CLEAR) begin
      r_ts <= '0;
    end else if (r_state == S_RUN) begin
      r_ts <= w_ts_last ? '0 : r_ts + TS_W'(1);
    end
  end

  // Per-node spike counters: saturate at all-ones, frozen outside RUN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (r_state == S_CLEAR) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        if (nodes_i[i] && (r_cnt[i] != c_cnt_max)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Argmax step: strict compare keeps the lowest index on ties.
  always_comb begin
    w_cur_cnt      = r_cnt[r_scan_idx];
    w_better       = (w_cur_cnt > r_best_cnt);
    w_best_idx_nxt = w_better ? r_scan_idx : r_best_idx;
    w_best_cnt_nxt = w_better ? w_cur_cnt  : r_best_cnt;
  end

  // Scan registers: one node visited per SCAN cycle in ascending order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_scan_idx <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_scan_idx <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
    end else if (r_state == S_SCAN) begin
      r_scan_idx <= r_scan_idx + IDX_W'(1);
      r_best_idx <= w_best_idx_nxt;
      r_best_cnt <= w_best_cnt_nxt;
    end
  end

  // Result registers: loaded on the final scan step, held through RESULT and IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_winner     <= '0;
      r_winner_cnt <= '0;
      r_no_spike   <= 1'b0;
    end else if ((r_state == S_SCAN) && w_scan_last && !abort_i) begin
      r_winner     <= w_best_idx_nxt;
      r_winner_cnt <= w_best_cnt_nxt;
      r_no_spike   <= (w_best_cnt_nxt == '0);
    end
  end

  assign winner_o     = r_winner;
  assign winner_cnt_o = r_winner_cnt;
  assign no_spike_o   = r_no_spike;

endmodule
`default_nettype wire
